uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive front end of the UART-ALU link. Deserialises the asynchronous rx line (8N1, 16x oversampling) and pushes each good byte into a small first-word-fall-through FIFO.
- Directly upstream of the operand/opcode interface FSM. That FSM sees i_data, rx_empty_signal and drives rd_signal into this block.
- Contains its own baud-tick generator, so it needs no external tick.

Parameters:
- BUS_SIZE, 8, data bits per frame and FIFO word width.
- SB_TICK, 16, oversampling ticks per stop bit (16 = 1 stop bit).
- CLK_DIV, 326, clk cycles per oversampling tick (100 MHz / (19200*16)).
- FIFO_ADDR_W, 2, FIFO depth = 2**FIFO_ADDR_W words.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting low clears all state immediately; release is synchronous to clk.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rd_signal  input  1  pop request, sampled each clk.
- o_data  output  BUS_SIZE  FIFO head word; valid while rx_empty_signal=0.
- rx_empty_signal  output  1  FIFO empty.
- rx_full_signal  output  1  FIFO full.
- overrun_err  output  1  one-cycle pulse: received byte dropped because FIFO full.
- framing_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values:
  - rx_empty_signal=1, rx_full_signal=0, o_data=0, overrun_err=0, framing_err=0.
  - Pointers and counters 0; FSM in IDLE.
  - Synchroniser flops = 1.
- Input sync: rx passes through a 2-FF synchroniser (rx_s). All FSM decisions use rx_s, which adds 2 clk latency.
- Tick generator:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - tick=1 for exactly one clk when counter==CLK_DIV-1.
  - Free-running; not restarted by start bits.
- Receiver FSM (s = tick count 0..15, n = bit count, b = shift register):
  - IDLE: on rx_s==0 go to START with s=0. No tick is required to leave IDLE.
  - START: on tick, if s==7:
    - rx_s==0: go to DATA with s=0, n=0.
    - rx_s==1: glitch; go to IDLE, nothing stored.
    - Otherwise (s≠7) s++.
  - DATA: on tick, if s==15: s=0, b={rx_s,b[BUS_SIZE-1:1]} (LSB first). If n==BUS_SIZE-1 go to STOP, else n++. Otherwise s++.
  - STOP: on tick, if s==SB_TICK-1:
    - rx_s==1: push b to FIFO.
    - rx_s==0: assert framing_err for one clk and discard b.
    - Either way go to IDLE. Otherwise s++.
  - A held-low line (break) produces one framing_err per frame time. This is intentional.
- FIFO:
  - Depth 2**FIFO_ADDR_W, registered pointers with one extra wrap bit.
  - First-word fall-through: o_data = mem[rd_ptr] while not empty.
  - Push and pop are single-cycle. rx_empty_signal falls on the clk after the push edge.
  - Pop: rd_signal=1 and not empty removes one word per clk. rd_signal held high drains one word per clk.
  - Pop while empty: ignored; pointers unchanged; no error.
  - Push while full, no pop: byte dropped, overrun_err pulses one clk, contents unchanged.
  - Push and pop in the same clk:
    - When full: both performed; occupancy stays full; no overrun.
    - When empty: push only.
- Reset asserted mid-frame: frame abandoned and FIFO flushed. After release, the receiver waits in IDLE for the next falling edge.

Test Plan (CLK_DIV=4, SB_TICK=16, FIFO_ADDR_W=2; bit time = 64 clk):
1. Single frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop).
   - Required: rx_empty_signal falls ~3 clk after the stop-bit mid sample, o_data=0xA5.
   - Then a 1-clk rd_signal pulse: rx_empty_signal=1 next clk.
2. Frames 0x05, 0x03, 0x20 back to back, no reads.
   - Required: FIFO holds 3 words, rx_full_signal=0.
   - Popping yields 0x05, 0x03, 0x20 in order, then empty.
3. Frames 0x01..0x05, no reads.
   - Required: rx_full_signal=1 after the 4th frame.
   - 5th frame produces an overrun_err pulse and is dropped.
   - Drain yields 0x01..0x04 only.
4. Frame 0x3C with stop bit driven 0.
   - Required: framing_err pulses 1 clk, rx_empty_signal stays 1.
   - Following valid frame 0x7E is received correctly.
5. rx low glitch of 20 clk (<8 ticks) then high.
   - Required: FSM returns to IDLE; no push, no error pulses.
6. Reset pulled low during data bit 3 of a frame, with 2 words already queued.
   - Required: outputs return to reset values immediately.
   - After release, frame 0x81 yields exactly one word, 0x81.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive front end: 8N1 deserialiser with 16x oversampling, its own
// baud-tick generator, and a first-word-fall-through receive FIFO.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to mid start bit; high there means glitch, abandon
// DATA  | sampling BUS_SIZE data bits at mid-bit, LSB first
// STOP  | counting to mid stop bit; push byte or flag framing error
module uart_rx_fifo #(
  parameter int BUS_SIZE    = 8,
  parameter int SB_TICK     = 16,
  parameter int CLK_DIV     = 326,
  parameter int FIFO_ADDR_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  input  logic                rd_signal,
  output logic [BUS_SIZE-1:0] o_data,
  output logic                rx_empty_signal,
  output logic                rx_full_signal,
  output logic                overrun_err,
  output logic                framing_err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W   = (BUS_SIZE > 1) ? $clog2(BUS_SIZE) : 1;
  localparam int DEPTH = 2 ** FIFO_ADDR_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [S_W-1:0]   S_MID    = S_W'(7);
  localparam logic [S_W-1:0]   S_BIT    = S_W'(15);
  localparam logic [S_W-1:0]   S_STOP   = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'(BUS_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // rx synchroniser and free-running oversampling tick
  // ---------------------------------------------------------------------
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      div_q     <= '0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      div_q     <= div_d;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [S_W-1:0]      s_q, s_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [BUS_SIZE-1:0] b_q, b_d;
  logic                fe_q, fe_d;
  logic                push_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    b_d      = b_q;
    fe_d     = 1'b0;
    push_req = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[BUS_SIZE-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (s_q == S_STOP) begin
            // A low stop bit returns to IDLE still low, so a held break
            // re-arms and reports once per frame time.
            if (rx_s_q) begin
              push_req = 1'b1;
            end else begin
              fe_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // First-word-fall-through FIFO, pointers carry one extra wrap bit
  // ---------------------------------------------------------------------
  logic [FIFO_ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [BUS_SIZE-1:0]    mem_q [DEPTH];
  logic                   ovr_q, ovr_d;
  logic                   empty, full, do_pop, do_push;
  logic [FIFO_ADDR_W-1:0] wr_addr, rd_addr;

  always_comb begin
    wr_addr = wr_ptr_q[FIFO_ADDR_W-1:0];
    rd_addr = rd_ptr_q[FIFO_ADDR_W-1:0];
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[FIFO_ADDR_W] != rd_ptr_q[FIFO_ADDR_W]) && (wr_addr == rd_addr);
    do_pop  = rd_signal && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push = push_req && (!full || do_pop);
    ovr_d   = push_req && full && !do_pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + (FIFO_ADDR_W + 1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (FIFO_ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_addr] <= b_q;
    end
  end

  assign o_data          = empty ? '0 : mem_q[rd_addr];
  assign rx_empty_signal = empty;
  assign rx_full_signal  = full;
  assign overrun_err     = ovr_q;
  assign framing_err     = fe_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed serial frames, expected bytes queued at
// stimulus time and compared by a monitor at every pop.
module tb_uart_rx_fifo;

  localparam int BUS_SIZE    = 8;
  localparam int SB_TICK     = 16;
  localparam int CLK_DIV     = 4;
  localparam int FIFO_ADDR_W = 2;
  localparam int BIT_CLK     = CLK_DIV * 16;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                rx = 1'b1;
  logic                rd_signal = 1'b0;
  logic [BUS_SIZE-1:0] o_data;
  logic                rx_empty_signal;
  logic                rx_full_signal;
  logic                overrun_err;
  logic                framing_err;

  uart_rx_fifo #(
    .BUS_SIZE(BUS_SIZE),
    .SB_TICK(SB_TICK),
    .CLK_DIV(CLK_DIV),
    .FIFO_ADDR_W(FIFO_ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rd_signal(rd_signal),
    .o_data(o_data),
    .rx_empty_signal(rx_empty_signal),
    .rx_full_signal(rx_full_signal),
    .overrun_err(overrun_err),
    .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int fall_cyc = -1;
  int ovr_cyc = 0;
  int fe_cyc = 0;
  int exp_ovr = 0;
  int exp_fe = 0;
  logic prev_empty = 1'b1;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, compares every word the DUT pops.
  always @(negedge clk) begin
    if (reset) begin
      if (prev_empty && !rx_empty_signal) fall_cyc = cyc;
      prev_empty = rx_empty_signal;
      if (overrun_err) ovr_cyc++;
      if (framing_err) fe_cyc++;
      if (rd_signal && !rx_empty_signal) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got %02h, no word expected", o_data);
        end else begin
          check("pop_data", 32'(o_data), 32'(exp_q.pop_front()));
        end
      end
    end else begin
      prev_empty = 1'b1;
    end
  end

  task automatic hold_bit();
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit good_stop);
    @(posedge clk);
    #1;
    rx = 1'b0;
    start_cyc = cyc;
    hold_bit();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold_bit();
    end
    if (good_stop) begin
      rx = 1'b1;
      hold_bit();
    end else begin
      // Low long enough to cover the mid-bit sample, then back to idle.
      rx = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (BIT_CLK - 40) @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string nm, input int n_exp);
    int n = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (rx_empty_signal) break;
      rd_signal = 1'b1;
      n++;
    end
    rd_signal = 1'b0;
    check({nm, "_pop_count"}, 32'(n), 32'(n_exp));
    check({nm, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    check({nm, "_empty_after"}, 32'(rx_empty_signal), 32'd1);
  endtask

  initial begin
    int delta;
    logic [7:0] t2_bytes [3];
    t2_bytes[0] = 8'h05;
    t2_bytes[1] = 8'h03;
    t2_bytes[2] = 8'h20;

    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", 32'(rx_empty_signal), 32'd1);
    check("rst_full", 32'(rx_full_signal), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_ovr", 32'(overrun_err), 32'd0);
    check("rst_fe", 32'(framing_err), 32'd0);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // 1: single frame, latency of empty fall, 1-clk pop
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    delta = fall_cyc - start_cyc;
    vectors++;
    if (delta < 604 || delta > 616) begin
      miscompares++;
      $display("FAIL t1_empty_fall_latency: got %0d clk expected 604..616", delta);
    end
    check("t1_empty", 32'(rx_empty_signal), 32'd0);
    check("t1_head", 32'(o_data), 32'h0000_00A5);
    @(posedge clk);
    #1;
    rd_signal = 1'b1;
    @(posedge clk);
    #1;
    rd_signal = 1'b0;
    check("t1_pop_empty", 32'(rx_empty_signal), 32'd1);
    check("t1_sb_left", 32'(exp_q.size()), 32'd0);

    // 2: three frames back to back
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(t2_bytes[i]);
      send_frame(t2_bytes[i], 1'b1);
    end
    check("t2_full", 32'(rx_full_signal), 32'd0);
    check("t2_empty", 32'(rx_empty_signal), 32'd0);
    drain("t2", 3);

    // 3: fill to full, fifth frame overruns
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    check("t3_full", 32'(rx_full_signal), 32'd1);
    check("t3_head", 32'(o_data), 32'h0000_0001);
    send_frame(8'h05, 1'b1);
    exp_ovr++;
    check("t3_ovr_pulses", 32'(ovr_cyc), 32'(exp_ovr));
    check("t3_full_after_ovr", 32'(rx_full_signal), 32'd1);
    drain("t3", 4);

    // 4: framing error then a good frame
    send_frame(8'h3C, 1'b0);
    exp_fe++;
    repeat (3 * BIT_CLK) @(posedge clk);
    #1;
    check("t4_fe_pulses", 32'(fe_cyc), 32'(exp_fe));
    check("t4_empty", 32'(rx_empty_signal), 32'd1);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    check("t4_head", 32'(o_data), 32'h0000_007E);
    drain("t4", 1);

    // 5: 20-clk low glitch is rejected
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * BIT_CLK) @(posedge clk);
    #1;
    check("t5_empty", 32'(rx_empty_signal), 32'd1);
    check("t5_fe_pulses", 32'(fe_cyc), 32'(exp_fe));
    check("t5_ovr_pulses", 32'(ovr_cyc), 32'(exp_ovr));
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    drain("t5", 1);

    // 6: reset during data bit 3 with two words queued
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    check("t6_queued_empty", 32'(rx_empty_signal), 32'd0);
    @(posedge clk);
    #1;
    rx = 1'b0;
    hold_bit();
    rx = 1'b1;
    hold_bit();
    rx = 1'b0;
    hold_bit();
    rx = 1'b0;
    hold_bit();
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_empty", 32'(rx_empty_signal), 32'd1);
    check("t6_rst_full", 32'(rx_full_signal), 32'd0);
    check("t6_rst_data", 32'(o_data), 32'd0);
    check("t6_rst_ovr", 32'(overrun_err), 32'd0);
    check("t6_rst_fe", 32'(framing_err), 32'd0);
    exp_q.delete();
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
    #1;
    check("t6_idle_empty", 32'(rx_empty_signal), 32'd1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    check("t6_head", 32'(o_data), 32'h0000_0081);
    drain("t6", 1);

    check("end_ovr_pulses", 32'(ovr_cyc), 32'(exp_ovr));
    check("end_fe_pulses", 32'(fe_cyc), 32'(exp_fe));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
